// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a single shared memory bus between an instruction-fetch
// requester (IF) and a load/store requester (MEM). MEM has fixed priority.
// Each access waits for bus_ack_i; after TIMEOUT bus cycles without an ack
// the access is aborted and reported with err_o alongside the done pulse.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   if_req_i, if_addr_i          fetch request / word address
//   if_data_o, if_done_o         fetched word, one-cycle completion pulse
//   mem_req_i, mem_we_i,         load/store request, direction, address,
//   mem_addr_i, mem_wdata_i,     store data, byte enables
//   mem_sel_i
//   mem_data_o, mem_done_o       load data, one-cycle completion pulse
//   err_o                        pulses with a done whose access timed out
//   bus_req_o, bus_we_o,         registered shared memory port
//   bus_addr_o, bus_wdata_o,
//   bus_sel_o
//   bus_ack_i, bus_rdata_i       memory completion and read data
//   if_stall_o, mem_stall_o      stall requests to pipeline control
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        if_stall_o,
    output logic        mem_stall_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_MEM = 2'd2
    } state_t;

    // Value of wait_cnt in the last bus cycle an access may still be acked.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    assign if_stall_o  = if_req_i & ~if_done_o;
    assign mem_stall_o = mem_req_i & ~mem_done_o;

    // Arbitration FSM: grants, bus payload latching, completion and timeout.
    // On an ack edge only the *other* requester may be granted, because the
    // completing requester is still presenting its old payload until it sees
    // its done pulse. During the done cycle itself (IDLE) its request is
    // taken as a fresh one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 16'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            bus_sel_o   <= 4'd0;
            if_data_o   <= 32'd0;
            mem_data_o  <= 32'd0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= 16'd0;
                    if (mem_req_i) begin
                        state       <= BUS_MEM;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        bus_sel_o   <= mem_sel_i;
                    end else if (if_req_i) begin
                        state       <= BUS_IF;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= 32'd0;
                        bus_sel_o   <= 4'b1111;
                    end else begin
                        bus_req_o <= 1'b0;
                    end
                end
                BUS_IF: begin
                    if (bus_ack_i) begin
                        if_data_o <= bus_rdata_i;
                        if_done_o <= 1'b1;
                        wait_cnt  <= 16'd0;
                        if (mem_req_i) begin
                            state       <= BUS_MEM;
                            bus_we_o    <= mem_we_i;
                            bus_addr_o  <= mem_addr_i;
                            bus_wdata_o <= mem_wdata_i;
                            bus_sel_o   <= mem_sel_i;
                        end else begin
                            state     <= IDLE;
                            bus_req_o <= 1'b0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abort: report done with error, fetched data untouched.
                        if_done_o <= 1'b1;
                        err_o     <= 1'b1;
                        wait_cnt  <= 16'd0;
                        state     <= IDLE;
                        bus_req_o <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                BUS_MEM: begin
                    if (bus_ack_i) begin
                        // Stores do not disturb the load data register.
                        if (!bus_we_o) begin
                            mem_data_o <= bus_rdata_i;
                        end else begin
                            mem_data_o <= mem_data_o;
                        end
                        mem_done_o <= 1'b1;
                        wait_cnt   <= 16'd0;
                        if (if_req_i) begin
                            state       <= BUS_IF;
                            bus_we_o    <= 1'b0;
                            bus_addr_o  <= if_addr_i;
                            bus_wdata_o <= 32'd0;
                            bus_sel_o   <= 4'b1111;
                        end else begin
                            state     <= IDLE;
                            bus_req_o <= 1'b0;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_done_o <= 1'b1;
                        err_o      <= 1'b1;
                        wait_cnt   <= 16'd0;
                        state      <= IDLE;
                        bus_req_o  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wait_cnt  <= 16'd0;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT = 4).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected completions are queued when a request is driven and popped by a
// monitor when a done pulse appears.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] mem_wdata_i = 32'd0;
    logic [3:0]  mem_sel_i = 4'd0;
    logic [31:0] mem_data_o;
    logic        mem_done_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'd0;
    logic        if_stall_o;
    logic        mem_stall_o;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_data_o(if_data_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
        .mem_data_o(mem_data_o), .mem_done_o(mem_done_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o)
    );

    typedef struct {
        logic        is_mem;
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waits;     // bus cycles without ack before the acked one
        logic        no_ack;    // never ack: access must time out
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_data;  // data output expected in the done cycle
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_mem, input logic err, input logic [31:0] data);
        exp_t e;
        e.is_mem = is_mem;
        e.err    = err;
        e.data   = data;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (if_done_o || mem_done_o) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got if_done=%b mem_done=%b, want none",
                             if_done_o, mem_done_o);
                end else begin
                    e = sb.pop_front();
                    check1("done_kind_mem", mem_done_o, e.is_mem);
                    check1("done_kind_if", if_done_o, ~e.is_mem);
                    check1("done_err", err_o, e.err);
                    check32("done_data", e.is_mem ? mem_data_o : if_data_o, e.data);
                end
            end else begin
                check1("err_without_done", err_o, 1'b0);
            end
        end
    end

    // One complete access from IDLE, checked cycle by cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] x_wdata;
        logic [3:0]  x_sel;
        logic        x_we;
        x_we    = v.is_mem ? v.we : 1'b0;
        x_wdata = v.is_mem ? v.wdata : 32'd0;
        x_sel   = v.is_mem ? v.sel : 4'b1111;
        if (v.is_mem) begin
            mem_req_i   = 1'b1;
            mem_we_i    = v.we;
            mem_addr_i  = v.addr;
            mem_wdata_i = v.wdata;
            mem_sel_i   = v.sel;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = v.addr;
        end
        push_exp(v.is_mem, v.exp_err, v.exp_data);
        #1;
        check1($sformatf("v%0d_stall_c0", idx), v.is_mem ? mem_stall_o : if_stall_o, 1'b1);
        @(negedge clk);
        for (int k = 0; k <= v.waits; k++) begin
            check1($sformatf("v%0d_bus_req_c%0d", idx, k + 1), bus_req_o, 1'b1);
            check32($sformatf("v%0d_bus_addr", idx), bus_addr_o, v.addr);
            check1($sformatf("v%0d_bus_we", idx), bus_we_o, x_we);
            check32($sformatf("v%0d_bus_wdata", idx), bus_wdata_o, x_wdata);
            check32($sformatf("v%0d_bus_sel", idx), {28'd0, bus_sel_o}, {28'd0, x_sel});
            bus_rdata_i = v.rdata;
            bus_ack_i   = (k == v.waits) && !v.no_ack;
            @(negedge clk);
        end
        bus_ack_i = 1'b0;
        check1($sformatf("v%0d_done", idx), v.is_mem ? mem_done_o : if_done_o, 1'b1);
        check1($sformatf("v%0d_bus_req_done", idx), bus_req_o, 1'b0);
        check1($sformatf("v%0d_stall_done", idx), v.is_mem ? mem_stall_o : if_stall_o, 1'b0);
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
        @(negedge clk);
        check1($sformatf("v%0d_done_single", idx), v.is_mem ? mem_done_o : if_done_o, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 1'b0, 32'h0010_0093, 1'b0, 32'h0010_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 1'b0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 3, 1'b0, 32'h5555_5555, 1'b0, 32'hCAFE_0001};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 3, 1'b1, 32'h7777_7777, 1'b1, 32'h0010_0093};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0018, 32'h0, 4'hF, 2, 1'b0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'hF, 3, 1'b1, 32'h6666_6666, 1'b1, 32'h1234_5678};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_010C, 32'h0102_0304, 4'b1000, 0, 1'b0, 32'h9999_9999, 1'b0, 32'h1234_5678};

        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_bus_req", bus_req_o, 1'b0);
        check1("rst_bus_we", bus_we_o, 1'b0);
        check32("rst_bus_addr", bus_addr_o, 32'd0);
        check32("rst_bus_wdata", bus_wdata_o, 32'd0);
        check32("rst_bus_sel", {28'd0, bus_sel_o}, 32'd0);
        check32("rst_if_data", if_data_o, 32'd0);
        check32("rst_mem_data", mem_data_o, 32'd0);
        check1("rst_if_done", if_done_o, 1'b0);
        check1("rst_mem_done", mem_done_o, 1'b0);
        check1("rst_err", err_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Collision: MEM first, IF granted on MEM's ack edge with no gap
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0040;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h0000_0100;
        mem_sel_i  = 4'hF;
        push_exp(1'b1, 1'b0, 32'h0BAD_0100);
        push_exp(1'b0, 1'b0, 32'h0BAD_0040);
        #1;
        check1("col_if_stall_c0", if_stall_o, 1'b1);
        @(negedge clk);
        check1("col_bus_req_c1", bus_req_o, 1'b1);
        check32("col_bus_addr_c1", bus_addr_o, 32'h0000_0100);
        check1("col_if_stall_c1", if_stall_o, 1'b1);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h0BAD_0100;
        @(negedge clk);
        check1("col_mem_done_c2", mem_done_o, 1'b1);
        check1("col_bus_req_c2", bus_req_o, 1'b1);
        check32("col_bus_addr_c2", bus_addr_o, 32'h0000_0040);
        check1("col_bus_we_c2", bus_we_o, 1'b0);
        check1("col_if_stall_c2", if_stall_o, 1'b1);
        mem_req_i   = 1'b0;
        bus_rdata_i = 32'h0BAD_0040;
        @(negedge clk);
        check1("col_if_done_c3", if_done_o, 1'b1);
        check1("col_bus_req_c3", bus_req_o, 1'b0);
        check1("col_if_stall_c3", if_stall_o, 1'b0);
        if_req_i  = 1'b0;
        bus_ack_i = 1'b0;
        @(negedge clk);

        // Back-to-back fetch: new address presented in the done cycle
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0080;
        push_exp(1'b0, 1'b0, 32'h1111_0080);
        @(negedge clk);
        check32("b2b_addr_a", bus_addr_o, 32'h0000_0080);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h1111_0080;
        @(negedge clk);
        check1("b2b_done_a", if_done_o, 1'b1);
        check1("b2b_no_regrant", bus_req_o, 1'b0);
        bus_ack_i = 1'b0;
        if_addr_i = 32'h0000_0084;
        push_exp(1'b0, 1'b0, 32'h2222_0084);
        @(negedge clk);
        check1("b2b_bus_req_b", bus_req_o, 1'b1);
        check32("b2b_addr_b", bus_addr_o, 32'h0000_0084);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h2222_0084;
        @(negedge clk);
        check1("b2b_done_b", if_done_o, 1'b1);
        if_req_i  = 1'b0;
        bus_ack_i = 1'b0;
        @(negedge clk);

        // Ack while idle must be ignored
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            check1("idle_ack_bus_req", bus_req_o, 1'b0);
            check1("idle_ack_if_done", if_done_o, 1'b0);
            check1("idle_ack_mem_done", mem_done_o, 1'b0);
        end
        check32("idle_ack_if_data", if_data_o, 32'h2222_0084);
        check32("idle_ack_mem_data", mem_data_o, 32'h0BAD_0100);
        bus_ack_i = 1'b0;

        // Requester drops early: access still completes
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0090;
        push_exp(1'b0, 1'b0, 32'h3333_0090);
        @(negedge clk);
        if_req_i = 1'b0;
        @(negedge clk);
        check1("drop_bus_req", bus_req_o, 1'b1);
        check32("drop_bus_addr", bus_addr_o, 32'h0000_0090);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h3333_0090;
        @(negedge clk);
        check1("drop_done", if_done_o, 1'b1);
        bus_ack_i = 1'b0;
        @(negedge clk);

        // Reset in the middle of a MEM access
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h0000_0300;
        mem_sel_i  = 4'hF;
        @(negedge clk);
        check1("rmid_bus_req_c1", bus_req_o, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("rmid_async_bus_req", bus_req_o, 1'b0);
        check32("rmid_async_bus_addr", bus_addr_o, 32'd0);
        check32("rmid_async_mem_data", mem_data_o, 32'd0);
        check32("rmid_async_if_data", if_data_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_exp(1'b1, 1'b0, 32'h4444_0300);
        @(negedge clk);
        check1("rmid_regrant", bus_req_o, 1'b1);
        check32("rmid_regrant_addr", bus_addr_o, 32'h0000_0300);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h4444_0300;
        @(negedge clk);
        check1("rmid_done", mem_done_o, 1'b1);
        mem_req_i = 1'b0;
        bus_ack_i = 1'b0;

        repeat (3) @(negedge clk);
        check32("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max bus cycles waited for bus_ack_i before abort (1..65535).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: if_req_i  in  1  fetch request, held until if_done_o.
REQ-005 SHALL have port: if_addr_i  in  32  fetch word address.
REQ-006 SHALL have port: if_data_o  out  32  fetched instruction.
REQ-007 SHALL have port: if_done_o  out  1  one-cycle fetch-complete pulse.
REQ-008 SHALL have port: mem_req_i  in  1  load/store request, held until mem_done_o.
REQ-009 SHALL have port: mem_we_i  in  1  1 = store, 0 = load.
REQ-010 SHALL have port: mem_addr_i  in  32  load/store address.
REQ-011 SHALL have port: mem_wdata_i  in  32  store data.
REQ-012 SHALL have port: mem_sel_i  in  4  byte enables.
REQ-013 SHALL have port: mem_data_o  out  32  load data.
REQ-014 SHALL have port: mem_done_o  out  1  one-cycle load/store-complete pulse.
REQ-015 SHALL have port: err_o  out  1  pulses with a done whose access timed out.
REQ-016 SHALL have ports: bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_wdata_o out 32, bus_sel_o out 4 -- shared memory port, all registered.
REQ-017 SHALL have ports: bus_ack_i in 1, bus_rdata_i in 32 -- memory completion and read data.
REQ-018 SHALL have ports: if_stall_o out 1, mem_stall_o out 1 -- stall requests to pipeline control.

Function
REQ-019 SHALL implement FSM states IDLE, BUS_IF, BUS_MEM.
REQ-020 IDLE: mem_req_i (unmasked) -> BUS_MEM; else if_req_i (unmasked) -> BUS_IF; else stay. MEM has fixed priority.
REQ-021 On grant edge SHALL latch granted payload onto bus_* (IF: we=0, sel=4'b1111, wdata=0) and set bus_req_o=1.
REQ-022 bus_* SHALL stay stable while in BUS_* state; bus_req_o=0 in IDLE.
REQ-023 In BUS_* state, edge with bus_ack_i=1 -> IDLE, bus_req_o=0, granted done pulse=1 next cycle; loads/fetches capture bus_rdata_i into mem_data_o/if_data_o on that edge.
REQ-024 Stores SHALL leave mem_data_o unchanged.
REQ-025 data outputs SHALL hold value until next capture.
REQ-026 Minimum latency: req asserted cycle 0 from IDLE, bus_req_o cycle 1, ack cycle 1 -> done cycle 2.
REQ-027 In the cycle a done pulse is high, the arbiter SHALL mask that requester's req (requester drops or re-presents new payload; new request honoured from following cycle); other requester may be granted that cycle.
REQ-028 SHALL count bus cycles per access; after TIMEOUT cycles without ack: -> IDLE, done pulse + err_o pulse, data output unchanged.
REQ-029 bus_ack_i while in IDLE SHALL be ignored.
REQ-030 if_stall_o = if_req_i & ~if_done_o; mem_stall_o = mem_req_i & ~mem_done_o (combinational).
REQ-031 Requests arriving simultaneously: MEM served first, IF granted in the done cycle of MEM (REQ-027), no idle gap.
REQ-032 Requester dropping req before done is protocol violation; in-flight access SHALL still complete and pulse done.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, timeout counter 0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_sel_o=0, if_data_o=0, mem_data_o=0, if_done_o=0, mem_done_o=0, err_o=0.
REQ-034 rst mid-access SHALL abandon access without done pulse; first grant possible on first edge after rst deasserts.

Verification
REQ-035 Fetch: if_req_i=1, if_addr_i=0x0000_0010, ack in first bus cycle with rdata 0x0010_0093 -> bus_addr_o=0x10 cycle 1, if_done_o cycle 2, if_data_o=0x0010_0093.
REQ-036 Collision: if_req_i and mem_req_i (load 0x100) both rise cycle 0, ack 1 cycle each -> MEM bus cycle 1, mem_done_o cycle 2, IF bus cycle 2 (granted in mem_done_o cycle), if_done_o cycle 3; if_stall_o high cycles 0-2.
REQ-037 Store: mem_we_i=1, addr 0x200, wdata 0xDEAD_BEEF, sel 4'b0011, ack after 3 wait cycles -> bus fields match and stable 4 cycles, mem_done_o once, mem_data_o unchanged.
REQ-038 Timeout: TIMEOUT=4, ack never asserted -> bus_req_o high exactly 4 cycles, then if_done_o=1 and err_o=1 same cycle, back to IDLE.
REQ-039 Reset mid-access: rst pulsed during BUS_MEM wait -> bus_req_o=0 asynchronously, no mem_done_o; after release with mem_req_i held, new access granted next edge.
REQ-040 Back-to-back fetch: if_req_i held high with new address in done cycle -> no regrant during done cycle, next fetch bus_req_o one cycle after done.
